multdiv_sequencer: RTL and testbench

Controller that sequences the multicycle multiply/divide unit for the 5-stage pipeline. It detects a `mul`/`div` in the D/X latch, freezes the front of the pipeline, and captures bypassed operands. It starts the unit, waits for completion or timeout, and then releases the pipeline with the result or an `$rstatus` exception write, which is muxed into the X/M latch.

---
 rtl/multdiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_multdiv_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Sequencer for the multicycle multiply/divide unit: freezes the front of the pipeline,
// starts the unit, waits for completion or timeout, and injects the result into X/M.
module multdiv_sequencer #(
    parameter int         TIMEOUT     = 40,
    parameter logic [4:0] RSTATUS_REG = 5'd30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_is_mul,
    input  logic        dx_is_div,
    input  logic [4:0]  dx_rd,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0]  TIMEOUT_LAST = 6'(TIMEOUT - 1);
    localparam logic [31:0] CODE_MUL_EXC = 32'd4;
    localparam logic [31:0] CODE_DIV_EXC = 32'd5;
    localparam logic [31:0] CODE_TIMEOUT = 32'd6;

    state_t      state_reg, state_next;
    logic [5:0]  count_reg, count_next;
    logic        op_div_reg, op_div_next;
    logic [4:0]  rd_reg, rd_next;
    logic [31:0] opa_reg, opa_next;
    logic [31:0] opb_reg, opb_next;
    logic        ctrl_mult_reg, ctrl_mult_next;
    logic        ctrl_div_reg, ctrl_div_next;
    logic        wb_valid_reg, wb_valid_next;
    logic [4:0]  wb_rd_reg, wb_rd_next;
    logic [31:0] wb_data_reg, wb_data_next;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= 6'd0;
            op_div_reg    <= 1'b0;
            rd_reg        <= 5'd0;
            opa_reg       <= 32'd0;
            opb_reg       <= 32'd0;
            ctrl_mult_reg <= 1'b0;
            ctrl_div_reg  <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= 5'd0;
            wb_data_reg   <= 32'd0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            op_div_reg    <= op_div_next;
            rd_reg        <= rd_next;
            opa_reg       <= opa_next;
            opb_reg       <= opb_next;
            ctrl_mult_reg <= ctrl_mult_next;
            ctrl_div_reg  <= ctrl_div_next;
            wb_valid_reg  <= wb_valid_next;
            wb_rd_reg     <= wb_rd_next;
            wb_data_reg   <= wb_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        op_div_next    = op_div_reg;
        rd_next        = rd_reg;
        opa_next       = opa_reg;
        opb_next       = opb_reg;
        ctrl_mult_next = 1'b0;
        ctrl_div_next  = 1'b0;
        wb_valid_next  = 1'b0;
        wb_rd_next     = wb_rd_reg;
        wb_data_next   = wb_data_reg;
        case (state_reg)
            IDLE: begin
                if (dx_is_mul || dx_is_div) begin
                    // mul wins when both decode flags are raised
                    state_next     = START;
                    op_div_next    = !dx_is_mul;
                    rd_next        = dx_rd;
                    opa_next       = operand_a;
                    opb_next       = operand_b;
                    ctrl_mult_next = dx_is_mul;
                    ctrl_div_next  = !dx_is_mul;
                end
            end
            START: begin
                state_next = BUSY;
                count_next = 6'd0;
            end
            BUSY: begin
                count_next = count_reg + 6'd1;
                if (md_ready) begin
                    state_next    = DONE;
                    wb_valid_next = 1'b1;
                    if (md_exception) begin
                        wb_rd_next   = RSTATUS_REG;
                        wb_data_next = op_div_reg ? CODE_DIV_EXC : CODE_MUL_EXC;
                    end else begin
                        wb_rd_next   = rd_reg;
                        wb_data_next = md_result;
                    end
                end else if (count_reg == TIMEOUT_LAST) begin
                    state_next    = DONE;
                    wb_valid_next = 1'b1;
                    wb_rd_next    = RSTATUS_REG;
                    wb_data_next  = CODE_TIMEOUT;
                end
            end
            DONE: begin
                // D/X still holds the completing instruction here, so no retrigger
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state_reg)
            IDLE:    stall = dx_is_mul || dx_is_div;
            START:   stall = 1'b1;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign md_ctrl_mult = ctrl_mult_reg;
    assign md_ctrl_div  = ctrl_div_reg;
    assign md_operand_a = opa_reg;
    assign md_operand_b = opb_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: stimulus pushes expected start pulses and
// writebacks into queues; a negedge monitor pops and compares them.
module tb_multdiv_sequencer;

    localparam int         TIMEOUT = 40;
    localparam logic [4:0] RS      = 5'd30;

    logic        clock = 1'b0;
    logic        reset;
    logic        dx_is_mul, dx_is_div;
    logic [4:0]  dx_rd;
    logic [31:0] operand_a, operand_b, md_result;
    logic        md_exception, md_ready;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_operand_a, md_operand_b;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .RSTATUS_REG(RS)) dut (
        .clock(clock), .reset(reset),
        .dx_is_mul(dx_is_mul), .dx_is_div(dx_is_div), .dx_rd(dx_rd),
        .operand_a(operand_a), .operand_b(operand_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    typedef struct { logic mult; logic [31:0] a; logic [31:0] b; } start_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; logic [31:0] a; logic [31:0] b; } wb_t;

    start_t start_q[$];
    wb_t    wb_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    bit     mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse and every writeback must match the oldest expectation
    start_t ms;
    wb_t    mw;
    always @(negedge clock) begin
        if (mon_en) begin
            if (md_ctrl_mult || md_ctrl_div) begin
                if (start_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_start: mult=%0b div=%0b, expected no pulse",
                             md_ctrl_mult, md_ctrl_div);
                end else begin
                    ms = start_q.pop_front();
                    check("start_mult", 32'(md_ctrl_mult), 32'(ms.mult));
                    check("start_div", 32'(md_ctrl_div), 32'(!ms.mult));
                    check("start_opa", md_operand_a, ms.a);
                    check("start_opb", md_operand_b, ms.b);
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_wb: rd=%0d data=0x%0h, expected no writeback", wb_rd, wb_data);
                end else begin
                    mw = wb_q.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(mw.rd));
                    check("wb_data", wb_data, mw.data);
                    check("held_opa", md_operand_a, mw.a);
                    check("held_opb", md_operand_b, mw.b);
                end
            end
        end
    end

    // Reference model: k<0 means the unit never reports ready
    task automatic run_op(input logic m, input logic d, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int k, input logic exc);
        logic [31:0] res;
        bit          timed_out;
        wb_t         w;
        start_t      s;
        int          c, stall_cnt, exp_stall;
        bit          done, noise;
        res       = m ? a * b : ((b == 0) ? 32'hFFFF_FFFF : a / b);
        timed_out = (k < 0) || (k >= TIMEOUT);
        s.mult = m; s.a = a; s.b = b;
        w.a = a; w.b = b;
        if (timed_out)  begin w.rd = RS; w.data = 32'd6; end
        else if (exc)   begin w.rd = RS; w.data = m ? 32'd4 : 32'd5; end
        else            begin w.rd = rd; w.data = res; end
        exp_stall = timed_out ? TIMEOUT + 2 : 3 + k;
        start_q.push_back(s);
        wb_q.push_back(w);
        noise = ($urandom_range(0, 1) == 1);
        c = 0; stall_cnt = 0; done = 0;
        while (!done && c < TIMEOUT + 20) begin
            @(posedge clock); #1;
            dx_is_mul = m; dx_is_div = d; dx_rd = rd;
            operand_a = (c == 0) ? a : $urandom;
            operand_b = (c == 0) ? b : $urandom;
            if (!timed_out && c == 2 + k) begin
                md_ready = 1'b1; md_exception = exc; md_result = res;
            end else begin
                md_ready = noise && (c == 1);
                md_exception = 1'($urandom_range(0, 1));
                md_result = $urandom;
            end
            @(negedge clock);
            if (stall) stall_cnt++;
            else begin
                done = 1;
                check("wb_valid_at_release", 32'(wb_valid), 32'd1);
            end
            c++;
        end
        check("stall_length", stall_cnt, exp_stall);
        md_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            dx_is_mul = 0; dx_is_div = 0; dx_rd = 5'($urandom);
            operand_a = $urandom; operand_b = $urandom;
            md_ready = 1'($urandom_range(0, 1));
            md_exception = 1'($urandom_range(0, 1));
            md_result = $urandom;
            @(negedge clock);
            check("idle_stall", 32'(stall), 32'd0);
        end
        md_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_ctrl"}, {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
        check({tag, "_opa"}, md_operand_a, 32'd0);
        check({tag, "_opb"}, md_operand_b, 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
    endtask

    task automatic reset_mid();
        start_t s;
        s.mult = 1'b1; s.a = $urandom; s.b = $urandom;
        start_q.push_back(s);
        for (int c = 0; c <= 8; c++) begin
            @(posedge clock); #1;
            dx_is_mul = 1; dx_is_div = 0; dx_rd = 5'd7;
            operand_a = (c == 0) ? s.a : $urandom;
            operand_b = (c == 0) ? s.b : $urandom;
            md_ready = 0;
            reset = (c == 8) ? 1'b0 : 1'b1;
        end
        @(posedge clock); #1;
        reset = 1'b1; dx_is_mul = 0; dx_is_div = 0;
        @(negedge clock);
        check_all_zero("mid_reset");
    endtask

    initial begin
        reset = 0; dx_is_mul = 0; dx_is_div = 0; dx_rd = 0;
        operand_a = 0; operand_b = 0; md_result = 0; md_exception = 0; md_ready = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1;
        mon_en = 1;
        idle(2);
        run_op(1, 0, 5'd5, 32'd6, 32'd7, 17, 0);
        idle(2);
        run_op(0, 1, 5'd3, 32'd9, 32'd0, 2, 1);
        idle(1);
        run_op(1, 0, 5'd8, $urandom, $urandom, 3, 0);
        run_op(0, 1, 5'd9, $urandom, $urandom, 4, 0);
        idle(2);
        run_op(1, 0, 5'd4, 32'd2, 32'd3, -1, 0);
        idle(2);
        run_op(0, 1, 5'd11, 32'd100, 32'd7, TIMEOUT - 1, 0);
        run_op(1, 0, 5'd12, 32'd5, 32'd5, 0, 0);
        run_op(1, 0, 5'd0, 32'd3, 32'd3, 1, 0);
        idle(1);
        reset_mid();
        idle(3);
        run_op(1, 0, 5'd6, 32'd9, 32'd9, 5, 0);
        idle(1);
        run_op(1, 1, 5'd13, 32'd4, 32'd4, 3, 1);
        for (int i = 0; i < 25; i++) begin
            logic m, d;
            int   k;
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 2));
            run_op(m, d, 5'($urandom), $urandom, $urandom, k,
                   ($urandom_range(0, 3) == 0));
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);
        check("start_q_drained", start_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
